// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin framebuffer write arbiter with registered write port.
// Define FB_CLEAR_EN to build in the full-framebuffer clear engine.
module fb_write_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_value,
    output logic              clear_busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_waddr,
    output logic [DATA_W-1:0] fb_din,
    output logic              grant_id
);

    logic              prio;
    logic              sel;
    logic              idle;
    logic              xfer;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

`ifdef FB_CLEAR_EN
    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_CLEAR = 1'b1;
    localparam logic [ADDR_W:0] CNT_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [0:0]        state;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] clr_val;

    assign idle       = (state == ST_IDLE);
    assign clear_busy = (state == ST_CLEAR);
    assign clr_we     = clear_busy;
    assign clr_addr   = cnt[ADDR_W-1:0];
    assign clr_data   = clr_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            clr_val <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state   <= ST_CLEAR;
                        cnt     <= '0;
                        clr_val <= clear_value;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + CNT_ONE;
                    if (cnt == CNT_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    logic unused_clear;

    assign unused_clear = ^{clear_start, clear_value};
    assign idle         = 1'b1;
    assign clear_busy   = 1'b0;
    assign clr_we       = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
`endif

    // prio names the requester that wins when both are valid
    assign sel        = (req0_valid && req1_valid) ? prio : req1_valid;
    assign xfer       = idle && !rst && (req0_valid || req1_valid);
    assign req0_ready = xfer && !sel;
    assign req1_ready = xfer && sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (xfer) begin
            prio <= ~sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_we    <= 1'b0;
            fb_waddr <= '0;
            fb_din   <= '0;
            grant_id <= 1'b0;
        end else if (clr_we) begin
            fb_we    <= 1'b1;
            fb_waddr <= clr_addr;
            fb_din   <= clr_data;
            grant_id <= 1'b0;
        end else if (xfer) begin
            fb_we    <= 1'b1;
            fb_waddr <= sel ? req1_addr : req0_addr;
            fb_din   <= sel ? req1_data : req0_data;
            grant_id <= sel;
        end else begin
            fb_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, clear/abort
// sequences and a random run against a behavioural model.
module tb_fb_write_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

`ifdef FB_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              req0_valid, req1_valid;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              clear_start;
    logic [DATA_W-1:0] clear_value;
    logic              clear_busy;
    logic              fb_we;
    logic [ADDR_W-1:0] fb_waddr;
    logic [DATA_W-1:0] fb_din;
    logic              grant_id;

    fb_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .clear_start(clear_start), .clear_value(clear_value),
        .clear_busy(clear_busy),
        .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_din(fb_din),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit              r;
        bit              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        bit              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
        bit              x0;
        bit              x1;
        bit              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        bit              gid;
        bit              all;
    } vec_t;

    vec_t tbl[12];

    // behavioural model: who wins, what lands on the port next cycle
    int m_last;
    bit m_busy;
    int m_idx;
    int m_cv;
    bit e_we;
    bit e_req;
    int e_addr, e_din, e_gid;

    task automatic model_reset();
        m_last = 1; m_busy = 0; m_idx = 0; m_cv = 0;
        e_we = 0; e_req = 0; e_addr = 0; e_din = 0; e_gid = 0;
    endtask

    task automatic step(input bit r,
                        input bit v0, input int a0, input int d0,
                        input bit v1, input int a1, input int d1,
                        input bit cs, input int cv);
        int g;
        rst = r;
        req0_valid = v0; req0_addr = ADDR_W'(a0); req0_data = DATA_W'(d0);
        req1_valid = v1; req1_addr = ADDR_W'(a1); req1_data = DATA_W'(d1);
        clear_start = cs; clear_value = DATA_W'(cv);
        #1;
        g = -1;
        if (!r && !m_busy) begin
            if (v0 && v1) g = 1 - m_last;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        check("req0_ready", 32'(req0_ready), 32'(g == 0));
        check("req1_ready", 32'(req1_ready), 32'(g == 1));
        check("clear_busy", 32'(clear_busy), 32'(m_busy));
        if (r) begin
            model_reset();
        end else if (m_busy) begin
            e_we = 1; e_req = 0; e_addr = m_idx; e_din = m_cv;
            m_idx++;
            if (m_idx == DEPTH) m_busy = 0;
        end else begin
            e_we  = (g >= 0);
            e_req = e_we;
            if (g == 0) begin
                e_addr = a0; e_din = d0; e_gid = 0; m_last = 0;
            end else if (g == 1) begin
                e_addr = a1; e_din = d1; e_gid = 1; m_last = 1;
            end
            if (cs && CLR_EN) begin
                m_busy = 1; m_idx = 0; m_cv = cv;
            end
        end
        @(posedge clk); #1;
        check("fb_we", 32'(fb_we), 32'(e_we));
        if (e_we || r) begin
            check("fb_waddr", 32'(fb_waddr), e_addr);
            check("fb_din", 32'(fb_din), e_din);
        end
        if (e_req || r) check("grant_id", 32'(grant_id), e_gid);
    endtask

    initial begin
        int busy_cnt;
        rst = 1'b1;
        req0_valid = 0; req0_addr = '0; req0_data = '0;
        req1_valid = 0; req1_addr = '0; req1_data = '0;
        clear_start = 0; clear_value = '0;
        model_reset();

        //           r v0 a0      d0    v1 a1      d1    x0 x1 we wa     wd    g  all
        tbl[0]  = '{1, 1, 12'h000, 4'h0, 1, 12'h000, 4'h0, 0, 0, 0, 12'h000, 4'h0, 0, 1};
        tbl[1]  = '{0, 1, 12'h010, 4'h1, 1, 12'h020, 4'h2, 1, 0, 1, 12'h010, 4'h1, 0, 1};
        tbl[2]  = '{0, 1, 12'h011, 4'h3, 1, 12'h021, 4'h4, 0, 1, 1, 12'h021, 4'h4, 1, 1};
        tbl[3]  = '{0, 1, 12'h012, 4'h5, 1, 12'h022, 4'h6, 1, 0, 1, 12'h012, 4'h5, 0, 1};
        tbl[4]  = '{0, 1, 12'h013, 4'h7, 1, 12'h023, 4'h8, 0, 1, 1, 12'h023, 4'h8, 1, 1};
        tbl[5]  = '{0, 0, 12'h000, 4'h0, 0, 12'h000, 4'h0, 0, 0, 0, 12'h000, 4'h0, 0, 0};
        tbl[6]  = '{0, 1, 12'h123, 4'h5, 0, 12'h000, 4'h0, 1, 0, 1, 12'h123, 4'h5, 0, 1};
        tbl[7]  = '{0, 0, 12'h000, 4'h0, 1, 12'hFFF, 4'hF, 0, 1, 1, 12'hFFF, 4'hF, 1, 1};
        tbl[8]  = '{0, 0, 12'h000, 4'h0, 1, 12'h000, 4'h0, 0, 1, 1, 12'h000, 4'h0, 1, 1};
        tbl[9]  = '{0, 1, 12'hABC, 4'h9, 1, 12'h456, 4'h3, 1, 0, 1, 12'hABC, 4'h9, 0, 1};
        tbl[10] = '{0, 1, 12'h001, 4'h1, 0, 12'h000, 4'h0, 1, 0, 1, 12'h001, 4'h1, 0, 1};
        tbl[11] = '{0, 1, 12'h555, 4'h2, 1, 12'hAAA, 4'hC, 0, 1, 1, 12'hAAA, 4'hC, 1, 1};

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst = tbl[i].r;
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            clear_start = 0;
            #1;
            check("tbl_req0_ready", 32'(req0_ready), 32'(tbl[i].x0));
            check("tbl_req1_ready", 32'(req1_ready), 32'(tbl[i].x1));
            @(posedge clk); #1;
            check("tbl_fb_we", 32'(fb_we), 32'(tbl[i].we));
            if (tbl[i].we || tbl[i].all) begin
                check("tbl_fb_waddr", 32'(fb_waddr), 32'(tbl[i].wa));
                check("tbl_fb_din", 32'(fb_din), 32'(tbl[i].wd));
                check("tbl_grant_id", 32'(grant_id), 32'(tbl[i].gid));
            end
            if (tbl[i].r) check("tbl_rst_busy", 32'(clear_busy), 32'd0);
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef FB_CLEAR_EN
        // clear with req1 parked on 0x0FF; same-cycle grant then stall
        step(0, 0, 0, 0, 1, 'h0FF, 3, 1, 'hA);
        busy_cnt = 0;
        for (int i = 0; i < DEPTH + 100; i++) begin
            if (!clear_busy) break;
            busy_cnt++;
            step(0, 0, 0, 0, 1, 'h0FF, 3, (i == 100), 5);
        end
        check("clear_busy_cycles", busy_cnt, DEPTH);
        step(0, 0, 0, 0, 1, 'h0FF, 3, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // abort mid-sweep at address 0x800 and restart from 0
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h3);
        for (int i = 0; i < DEPTH; i++) begin
            if (m_idx == 'h800) break;
            step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        check("abort_point", m_idx, 'h800);
        step(1, 1, 'h10, 1, 0, 0, 0, 0, 0);
        check("abort_fb_we", 32'(fb_we), 32'd0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 'h6);
        step(0, 1, 'h22, 2, 0, 0, 0, 0, 0);
        check("restart_addr", 32'(fb_waddr), 32'd0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        // clear_start has no effect in this build
        step(0, 1, 'h321, 6, 0, 0, 0, 1, 'hA);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 'hA);
            check("noclr_busy", 32'(clear_busy), 32'd0);
        end
        step(0, 1, 'h100, 1, 1, 'h200, 2, 1, 'h5);
`endif

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 799) == 0), int'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001: The block SHALL have parameter ADDR_W, default 12, meaning the framebuffer write-address width (depth = 2**ADDR_W).
REQ-002: The block SHALL have parameter DATA_W, default 4, meaning the pixel data width.
REQ-003: Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004: Port rst  in  1  synchronous, active-high reset.
REQ-005: Ports req0_valid / req1_valid  in  1  requester n has a write pending.
REQ-006: Ports req0_addr / req1_addr  in  ADDR_W  write address of requester n.
REQ-007: Ports req0_data / req1_data  in  DATA_W  write data of requester n.
REQ-008: Ports req0_ready / req1_ready  out  1  the write of requester n is accepted this cycle.
REQ-009: Port clear_start  in  1  one-cycle pulse that starts a full-framebuffer clear.
REQ-010: Port clear_value  in  DATA_W  fill value used by the clear.
REQ-011: Port clear_busy  out  1  a clear sweep is in progress.
REQ-012: Port fb_we  out  1  registered write enable to the framebuffer.
REQ-013: Port fb_waddr  out  ADDR_W  registered framebuffer write address.
REQ-014: Port fb_din  out  DATA_W  registered framebuffer write data.
REQ-015: Port grant_id  out  1  registered index of the requester that produced the current fb_we pulse.

Function
REQ-016: Transfer SHALL occur when reqN_valid && reqN_ready; reqN_ready SHALL be combinational, high only when reqN_valid is high and the arbiter selects N.
REQ-017: The arbiter SHALL grant at most one requester per cycle.
REQ-018: Arbitration SHALL be round-robin: after a grant to N, priority goes to the other requester; when only one requester is valid, that requester SHALL be granted.
REQ-019: A granted write SHALL appear on fb_we/fb_waddr/fb_din/grant_id exactly one cycle after the transfer cycle; fb_we SHALL be 0 in any cycle following a cycle without a transfer or clear write.
REQ-020: The FSM SHALL have states IDLE and CLEAR; IDLE -> CLEAR on clear_start; CLEAR -> IDLE in the cycle after the write to address 2**ADDR_W-1 is issued.
REQ-021: In CLEAR, both readys SHALL be 0, and the block SHALL issue one write per cycle to addresses 0, 1, ..., 2**ADDR_W-1 in order, with data equal to clear_value captured at clear_start.
REQ-022: A requester that has clear_start asserted in the same IDLE cycle SHALL still be granted in that cycle; the first clear write SHALL follow one cycle later.
REQ-023: clear_busy SHALL be high for exactly the 2**ADDR_W cycles in CLEAR; clear_start during CLEAR SHALL be ignored.
REQ-024: The clear address counter SHALL be ADDR_W+1 bits wide, so the terminal address is detected without wrap-around aliasing.
REQ-025: Requester valid/addr/data held during CLEAR SHALL NOT be lost; the pending write SHALL be granted in the first IDLE cycle.

Reset
REQ-026: On rst, the block SHALL set fb_we=0, fb_waddr=0, fb_din=0, grant_id=0, clear_busy=0, state=IDLE, clear counter=0, and round-robin priority to req0.
REQ-027: rst asserted mid-clear SHALL abort the sweep; no fb_we pulse SHALL occur in the cycle after rst.
REQ-028: While rst is high, req0_ready and req1_ready SHALL be 0.

Configuration
REQ-029: With macro FB_CLEAR_EN defined, the clear engine (REQ-020..REQ-025) SHALL be compiled in.
REQ-030: Without FB_CLEAR_EN, there SHALL be no FSM or counter; clear_start and clear_value SHALL be ignored, clear_busy SHALL be tied to 0, and arbitration SHALL be otherwise identical.

Verification
REQ-031: Scenario: req0 only, addr 0x123, data 0x5 -> req0_ready=1 in the same cycle; next cycle fb_we=1, fb_waddr=0x123, fb_din=0x5, grant_id=0.
REQ-032: Scenario: both valid for 4 cycles after reset -> grants 0,1,0,1, with fb_waddr following the respective addresses one cycle later.
REQ-033: Scenario: clear_start with clear_value=0xA -> clear_busy high for 4096 cycles; writes cover addresses 0x000..0xFFF, all with data 0xA; the next cycle returns to IDLE.
REQ-034: Scenario: req1 valid with addr 0x0FF throughout the clear -> req1_ready=0 during CLEAR; the first IDLE cycle gives req1_ready=1, and write 0x0FF appears after the last clear write.
REQ-035: Scenario: rst at clear address 0x800 -> the cycle after rst has fb_we=0 and clear_busy=0; a new clear_start restarts at address 0x000.
REQ-036: Scenario: build without FB_CLEAR_EN and pulse clear_start -> clear_busy stays 0, no fb_we pulse occurs, and requests are granted normally.
